seq_divider: RTL and testbench

//   Iterative restoring divider: the division counterpart of the CLA array multiplier for MULT/MULTU.

---
 rtl/seq_divider.sv | 152 +++++++++++++++
 tb/tb_seq_divider.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
`timescale 1ns/1ps
// Iterative restoring divider for MIPS DIV/DIVU: one quotient bit per cycle,
// quotient on lo, remainder on hi, fixed latency for every operand pair.
module seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi,
   output logic             div_by_zero,
   output logic [1:0]       dbg_state
);

   localparam int CW = $clog2(WIDTH + 1);

   // Handshake: start is sampled at a rising edge only while busy=0; that edge is the
   // accept edge. busy stays high until the edge after the single-cycle done pulse.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvsr_q, dvsr_d;
   logic [WIDTH-1:0] raw_q, raw_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic             sgnq_q, sgnq_d;
   logic             sgnr_q, sgnr_d;
   logic             zero_q, zero_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH-1:0] dvnd_abs;
   logic [WIDTH-1:0] dvsr_abs;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH+1:0] trial;

   // Magnitudes; the most negative value maps onto itself, which is correct read unsigned.
   assign dvnd_abs = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
   assign dvsr_abs = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

   // The shifted partial remainder needs one extra bit; the trial one more for its sign.
   assign rem_sh = {rem_q, quo_q[WIDTH-1]};
   assign trial  = {1'b0, rem_sh} - {2'b00, dvsr_q};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvsr_q  <= '0;
         raw_q   <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
         sgnq_q  <= 1'b0;
         sgnr_q  <= 1'b0;
         zero_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvsr_q  <= dvsr_d;
         raw_q   <= raw_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         sgnq_q  <= sgnq_d;
         sgnr_q  <= sgnr_d;
         zero_q  <= zero_d;
         dbz_q   <= dbz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvsr_d  = dvsr_q;
      raw_d   = raw_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      sgnq_d  = sgnq_q;
      sgnr_d  = sgnr_q;
      zero_d  = zero_q;
      dbz_d   = dbz_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               cnt_d   = CW'(WIDTH);
               rem_d   = '0;
               quo_d   = dvnd_abs;
               dvsr_d  = dvsr_abs;
               raw_d   = dividend;
               sgnq_d  = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
               sgnr_d  = is_signed & dividend[WIDTH-1];
               zero_d  = (divisor == '0);
            end
         end
         S_RUN: begin
            // WIDTH iterations, then one more RUN cycle that observes the empty counter.
            if (cnt_q != '0) begin
               quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH+1]};
               rem_d = trial[WIDTH+1] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
               cnt_d = cnt_q - CW'(1);
            end else begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            state_d = S_DONE;
            dbz_d   = zero_q;
            if (zero_q) begin
               lo_d = '1;
               hi_d = raw_q;
            end else begin
               lo_d = sgnq_q ? -quo_q : quo_q;
               hi_d = sgnr_q ? -rem_q : rem_q;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);
   assign lo          = lo_q;
   assign hi          = hi_q;
   assign div_by_zero = dbz_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_seq_divider.sv
`timescale 1ns/1ps
// Bench for seq_divider: arithmetic reference model with a per-cycle compare,
// plus directed operations with hand-computed results.
module tb_seq_divider;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] lo, hi;
  logic [1:0]   dbg_state;

  int total = 0;
  int bad = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .lo(lo), .hi(hi), .div_by_zero(div_by_zero), .dbg_state(dbg_state)
  );

  // clock / reset / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [2*W:0] act, input logic [2*W:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference result packed as {div_by_zero, hi, lo}.
  function automatic logic [2*W:0] ref_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, q, r;
    if (b == '0) return {1'b1, a, {W{1'b1}}};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {1'b0, r[W-1:0], q[W-1:0]};
  endfunction

  // scoreboard: results queued at accept, retired when done is due
  logic [2*W:0] exp_q[$];
  logic         m_active = 1'b0;
  int           m_t = 0;
  logic [W-1:0] m_lo = '0, m_hi = '0;
  logic         m_dbz = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_t = 0;
      m_lo = '0;
      m_hi = '0;
      m_dbz = 1'b0;
      exp_q.delete();
    end else if (m_active) begin
      m_t++;
      if (m_t == LAT) begin
        logic [2*W:0] r;
        r = exp_q.pop_front();
        {m_dbz, m_hi, m_lo} = r;
      end
      if (m_t == LAT + 1) m_active = 1'b0;
    end else if (start) begin
      m_active = 1'b1;
      m_t = 0;
      exp_q.push_back(ref_div(is_signed, dividend, divisor));
    end
  end

  always @(negedge clk) begin
    chk("busy", {64'b0, busy}, {64'b0, m_active});
    chk("done", {64'b0, done}, {64'b0, (m_active && m_t == LAT)});
    chk("lo", {33'b0, lo}, {33'b0, m_lo});
    chk("hi", {33'b0, hi}, {33'b0, m_hi});
    chk("div_by_zero", {64'b0, div_by_zero}, {64'b0, m_dbz});
  end

  // driver: one operation from an idle unit, checked against literals
  task automatic run_op(input string name, input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] el, input logic [W-1:0] eh, input logic ez);
    int lat;
    start = 1'b1;
    is_signed = sgn;
    dividend = a;
    divisor = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < LAT + 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({name, "_latency"}, 65'(lat), 65'(LAT));
    chk({name, "_lo"}, {33'b0, lo}, {33'b0, el});
    chk({name, "_hi"}, {33'b0, hi}, {33'b0, eh});
    chk({name, "_dbz"}, {64'b0, div_by_zero}, {64'b0, ez});
    @(posedge clk);
    #1;
    chk({name, "_busy_after"}, {64'b0, busy}, 65'b0);
  endtask

  initial begin
    int nd;
    int wait_cnt;

    // pin the reference model with hand-worked values
    chk("model_100_7", ref_div(1'b0, 32'd100, 32'd7), {1'b0, 32'd2, 32'd14});
    chk("model_m7_2", ref_div(1'b1, 32'hFFFFFFF9, 32'd2), {1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD});
    chk("model_ovf", ref_div(1'b1, 32'h80000000, 32'hFFFFFFFF), {1'b0, 32'h0, 32'h80000000});
    chk("model_div0", ref_div(1'b1, 32'd5, 32'd0), {1'b1, 32'd5, 32'hFFFFFFFF});

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {64'b0, busy}, 65'b0);
    chk("reset_done", {64'b0, done}, 65'b0);
    chk("reset_lo", {33'b0, lo}, 65'b0);
    chk("reset_hi", {33'b0, hi}, 65'b0);
    chk("reset_dbz", {64'b0, div_by_zero}, 65'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    run_op("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
    run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0);
    run_op("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1);
    run_op("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
    run_op("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0);
    run_op("divu_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0);
    run_op("div_m100_7", 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);

    // start held for 40 cycles with changing operands
    nd = 0;
    start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      is_signed = 1'(i % 2);
      dividend = 32'(1000 + i * 37);
      divisor = 32'((i % 5) + 2);
      @(posedge clk);
      #1;
      if (done) begin
        nd++;
        chk("hold_first_lo", {33'b0, lo}, 65'd500);
        chk("hold_first_hi", {33'b0, hi}, 65'd0);
      end
    end
    start = 1'b0;
    chk("hold_done_count", 65'(nd), 65'd1);
    wait_cnt = 0;
    while (!done && wait_cnt < LAT + 5) begin
      @(posedge clk);
      #1;
      wait_cnt++;
    end
    chk("hold_second_done", {64'b0, done}, 65'b1);
    chk("hold_second_lo", {33'b0, lo}, 65'd777);
    chk("hold_second_hi", {33'b0, hi}, 65'd1);
    @(posedge clk);
    #1;

    // reset in the middle of RUN
    start = 1'b1;
    is_signed = 1'b0;
    dividend = 32'd1000;
    divisor = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {64'b0, busy}, 65'b0);
    chk("abort_done", {64'b0, done}, 65'b0);
    chk("abort_lo", {33'b0, lo}, 65'b0);
    chk("abort_hi", {33'b0, hi}, 65'b0);
    chk("abort_dbz", {64'b0, div_by_zero}, 65'b0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    nd = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    chk("abort_no_done", 65'(nd), 65'd0);
    run_op("divu_20_6", 1'b0, 32'd20, 32'd6, 32'd3, 32'd2, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
